accum_rmw_engine: RTL and testbench
===================================

# accum_rmw_engine

Physical accumulator memory stage directly downstream of the accumulator bus arbiter. It consumes the arbitrated write and read command/data streams and owns the `NUM_BANKS` SIMD SRAM banks. It executes plain writes and read-modify-write accumulates at one write per cycle, never back-pressuring writes, and returns read data with fixed latency. It throttles reads through `rd_ready` whenever the bank read port is busy or a read would hit an in-flight write.

## Interface
- `NUM_BANKS`, 4: SIMD bank count.
- `DATA_WIDTH`, 64: bits per bank word.
- `LANE_WIDTH`, 16: accumulate lane width; `DATA_WIDTH % LANE_WIDTH == 0`.
- `ADDR_WIDTH`, 9: word address within a zone.
- `ZONE_WIDTH`, 2: zone id width; bank depth is `2^(ZONE_WIDTH+ADDR_WIDTH)`.
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr_valid` in 1: write command valid.
- `accum_en` in 1: 1 = accumulate, 0 = overwrite.
- `wr_mask` in NUM_BANKS: bank enable.
- `wr_addr` in ADDR_WIDTH: write word address.
- `wr_zone_id` in ZONE_WIDTH: write zone.
- `wvalid` in 1: write data valid; always co-asserted with `wr_valid`.
- `wdata` in NUM_BANKS*DATA_WIDTH: write data, bank b at `[b*DATA_WIDTH +: DATA_WIDTH]`.
- `rd_valid` in 1: read command valid.
- `rd_mask` in NUM_BANKS: banks to read.
- `rd_addr` in ADDR_WIDTH: read word address.
- `rd_zone_id` in ZONE_WIDTH: read zone.
- `rd_ready` out 1: read accepted when `rd_valid && rd_ready`.
- `rvalid` out 1: read data valid.
- `rdata` out NUM_BANKS*DATA_WIDTH: read data.

## Operation
- Physical address is `{zone_id, addr}`.
- A write is accepted in any cycle with `wr_valid && wvalid`; there is no write back-pressure. `wr_valid` without `wvalid` is ignored.
- Write pipeline: S0 (accept; for an accumulate, issue the bank read), S1 (old data returns; form the sum; register into S2), S2 (bank write), S3 (retire register holding the last written addr/mask/data).
- Plain writes traverse S0–S2 unchanged so write order is preserved.
- Sum, per masked bank and per lane: `(old + new) mod 2^LANE_WIDTH`. Lanes are independent, with no carry between lanes. Unmasked banks are neither read nor written.
- Forwarding at S1, per bank, applies when the physical address matches and that bank's mask bit is set. S2 data wins over S3 data, which wins over SRAM data. This covers the back-to-back case and the read-during-write-returns-old case.
- `rd_ready` is combinational: `rstn && !(wr_valid && wvalid && accum_en) && !hazard`.
  - `hazard`: the read physical address equals the address in a valid S1 or S2 entry with an overlapping mask.
- A read and a plain write accepted in the same cycle: the read is ordered first and returns pre-write data.
- `rdata` for unmasked banks is 0. `rdata` is all-zero whenever `rvalid` = 0.
- Bank RAM: simple dual-port, 1-cycle read latency, read-during-write returns old data. Contents are not reset.

## Timing
- Reset values: `rvalid` = 0, `rdata` = 0, `rd_ready` = 0, S1/S2/S3 valids = 0.
- A reset asserted mid-operation discards pending writes and any pending read response.
- A read accepted at cycle N gives `rvalid`/`rdata` at N+1.
- A write accepted at N reaches SRAM at N+2. Reads to that address stall at N+1 and N+2 and are accepted from N+3 with the new value.
- An accumulate accepted at N forces `rd_ready` = 0 at N only.
- Sustained throughput: 1 write/cycle. Reads get 1/cycle when no accumulate is accepted and no hazard is present.

## Configuration
- `ACCUM_PERF_CNT_EN` defined: adds outputs `perf_accum_cnt` (32) and `perf_rd_stall_cnt` (32).
  - `perf_accum_cnt` counts accepted accumulates.
  - `perf_rd_stall_cnt` counts cycles with `rd_valid && !rd_ready`.
  - Both saturate at `2^32-1` and reset to 0.
- `ACCUM_PERF_CNT_EN` not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `accum_pkg`: pipeline entry struct (valid, accum_en, mask, physical addr, data), physical-address width constant, and a lane-add function.
- Sub-module `accum_bank_ram` (one simple dual-port bank), instantiated NUM_BANKS times.

## Test plan
- Plain write to zone 0, addr 5, mask 4'hF, every lane 0x0003, then read addr 5 at N+3 → `rvalid` at N+4 with all lanes 0x0003.
- Lane at 0xFFFF, accumulate 0x0002 → reads back 0x0001; the neighbouring lane is unaffected.
- Four accumulates of +1 to addr 7 in consecutive cycles from 0 → reads back 4 in every lane (exercises S2 and S3 forwarding).
- Accumulate to addr 9 at N with `rd_valid` to addr 9 held → `rd_ready` is 0 at N, N+1 and N+2; accepted at N+3 with the updated value.
- Accumulate with mask 4'b0101, then read with mask 4'b0011 → bank 0 holds the sum, bank 1 holds its old value, banks 2–3 return 0.
- Reset pulse while S1/S2 are valid → no SRAM write occurs, `rvalid` = 0, perf counters = 0 when enabled.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types for the accumulator memory stage: pipeline entries and lane-wise adder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package accum_pkg;

    localparam int ACC_NUM_BANKS   = 4;
    localparam int ACC_DATA_WIDTH  = 64;
    localparam int ACC_LANE_WIDTH  = 16;
    localparam int ACC_ADDR_WIDTH  = 9;
    localparam int ACC_ZONE_WIDTH  = 2;
    localparam int ACC_PADDR_WIDTH = ACC_ZONE_WIDTH + ACC_ADDR_WIDTH;

    // S1 entry: still needs accum_en to choose between sum and overwrite
    typedef struct packed {
        logic                                    vld;
        logic                                    accum_en;
        logic [ACC_NUM_BANKS-1:0]                mask;
        logic [ACC_PADDR_WIDTH-1:0]              paddr;
        logic [ACC_NUM_BANKS*ACC_DATA_WIDTH-1:0] dat;
    } pipe_entry_t;

    // S2/S3 entry: data is final, only the write target matters
    typedef struct packed {
        logic                                    vld;
        logic [ACC_NUM_BANKS-1:0]                mask;
        logic [ACC_PADDR_WIDTH-1:0]              paddr;
        logic [ACC_NUM_BANKS*ACC_DATA_WIDTH-1:0] dat;
    } wr_entry_t;

    // Ripple add with the carry killed at every lane boundary, so lanes wrap independently.
    function automatic logic [ACC_DATA_WIDTH-1:0] lane_add(
        input logic [ACC_DATA_WIDTH-1:0] a,
        input logic [ACC_DATA_WIDTH-1:0] b,
        input int                        lane_w
    );
        logic [ACC_DATA_WIDTH-1:0] s;
        logic                      c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < ACC_DATA_WIDTH; i++) begin
            if ((i % lane_w) == 0) c = 1'b0;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

endpackage

// File: rtl/accum_bank_ram.sv
// One SIMD bank: simple dual-port RAM, read-during-write returns old data, contents not reset.
// Latency: 1 cycle read.
// Backpressure: none; caller arbitrates the single read port.
module accum_bank_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/accum_rmw_engine.sv
// Accumulator memory stage: plain writes and read-modify-write accumulates over NUM_BANKS banks; ACCUM_PERF_CNT_EN adds perf counters.
// Latency: write reaches SRAM 2 cycles after accept; read data 1 cycle after accept.
// Backpressure: writes never stalled; rd_ready drops for an accepted accumulate or an S1/S2 address hazard.
module accum_rmw_engine
    import accum_pkg::*;
#(
    parameter int NUM_BANKS  = ACC_NUM_BANKS,
    parameter int DATA_WIDTH = ACC_DATA_WIDTH,
    parameter int LANE_WIDTH = ACC_LANE_WIDTH,
    parameter int ADDR_WIDTH = ACC_ADDR_WIDTH,
    parameter int ZONE_WIDTH = ACC_ZONE_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wr_valid,
    input  logic                            accum_en,
    input  logic [NUM_BANKS-1:0]            wr_mask,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [ZONE_WIDTH-1:0]           wr_zone_id,
    input  logic                            wvalid,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
    input  logic                            rd_valid,
    input  logic [NUM_BANKS-1:0]            rd_mask,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [ZONE_WIDTH-1:0]           rd_zone_id,
    output logic                            rd_ready,
    output logic                            rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
`ifdef ACCUM_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_accum_cnt,
    output logic [31:0]                     perf_rd_stall_cnt
`endif
);

    localparam int PAW = ZONE_WIDTH + ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;

    logic                      wr_fire;
    logic                      accum_fire;
    logic                      hazard;
    logic                      rd_fire;
    logic [PAW-1:0]            wr_paddr;
    logic [PAW-1:0]            rd_paddr;
    logic [PAW-1:0]            ram_raddr;
    logic [NUM_BANKS-1:0]      ram_re;
    logic [NUM_BANKS-1:0]      rd_mask_q;
    logic [NUM_BANKS*DW-1:0]   sum_dat;

    pipe_entry_t s1;
    wr_entry_t   s2;
    wr_entry_t   s3;

    assign wr_fire    = wr_valid && wvalid;
    assign accum_fire = wr_fire && accum_en;
    assign wr_paddr   = {wr_zone_id, wr_addr};
    assign rd_paddr   = {rd_zone_id, rd_addr};

    // S3 is already in SRAM by the time a read issues, so only S1/S2 can be stale
    assign hazard = (s1.vld && (s1.paddr == rd_paddr) && (|(s1.mask & rd_mask))) ||
                    (s2.vld && (s2.paddr == rd_paddr) && (|(s2.mask & rd_mask)));

    assign rd_ready = rstn && !accum_fire && !hazard;
    assign rd_fire  = rd_valid && rd_ready;

    // An accepted accumulate owns the read port; rd_ready is low in that cycle
    assign ram_raddr = accum_fire ? wr_paddr : rd_paddr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DW-1:0] ram_q;
        logic [DW-1:0] old_dat;
        logic          s2_fwd;
        logic          s3_fwd;

        assign ram_re[b] = accum_fire ? wr_mask[b] : (rd_fire && rd_mask[b]);

        accum_bank_ram #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (PAW)
        ) u_ram (
            .clk   (clk),
            .we    (s2.vld && s2.mask[b]),
            .waddr (s2.paddr),
            .wdata (s2.dat[b*DW +: DW]),
            .re    (ram_re[b]),
            .raddr (ram_raddr),
            .rdata (ram_q)
        );

        assign s2_fwd  = s2.vld && (s2.paddr == s1.paddr) && s2.mask[b];
        assign s3_fwd  = s3.vld && (s3.paddr == s1.paddr) && s3.mask[b];
        assign old_dat = s2_fwd ? s2.dat[b*DW +: DW] :
                         s3_fwd ? s3.dat[b*DW +: DW] : ram_q;

        assign sum_dat[b*DW +: DW] = s1.accum_en ? lane_add(old_dat, s1.dat[b*DW +: DW], LANE_WIDTH)
                                                 : s1.dat[b*DW +: DW];

        assign rdata[b*DW +: DW] = (rvalid && rd_mask_q[b]) ? ram_q : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            rvalid    <= 1'b0;
            rd_mask_q <= '0;
        end else begin
            s1        <= '{vld: wr_fire, accum_en: accum_en, mask: wr_mask,
                           paddr: wr_paddr, dat: wdata};
            s2        <= '{vld: s1.vld, mask: s1.mask, paddr: s1.paddr, dat: sum_dat};
            s3        <= s2;
            rvalid    <= rd_fire;
            rd_mask_q <= rd_mask;
        end
    end

`ifdef ACCUM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_accum_cnt    <= '0;
            perf_rd_stall_cnt <= '0;
        end else begin
            if (accum_fire && (perf_accum_cnt != 32'hFFFF_FFFF))
                perf_accum_cnt <= perf_accum_cnt + 32'd1;
            if (rd_valid && !rd_ready && (perf_rd_stall_cnt != 32'hFFFF_FFFF))
                perf_rd_stall_cnt <= perf_rd_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accum_rmw_engine.sv
// Directed bench for accum_rmw_engine: table of write-then-read vectors plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_accum_rmw_engine;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wr_valid;
    logic         accum_en;
    logic [3:0]   wr_mask;
    logic [8:0]   wr_addr;
    logic [1:0]   wr_zone_id;
    logic         wvalid;
    logic [255:0] wdata;
    logic         rd_valid;
    logic [3:0]   rd_mask;
    logic [8:0]   rd_addr;
    logic [1:0]   rd_zone_id;
    logic         rd_ready;
    logic         rvalid;
    logic [255:0] rdata;
`ifdef ACCUM_PERF_CNT_EN
    logic [31:0]  perf_accum_cnt;
    logic [31:0]  perf_rd_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int n_accum  = 0;

    always #5 clk = ~clk;

    accum_rmw_engine dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_valid   (wr_valid),
        .accum_en   (accum_en),
        .wr_mask    (wr_mask),
        .wr_addr    (wr_addr),
        .wr_zone_id (wr_zone_id),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .rd_valid   (rd_valid),
        .rd_mask    (rd_mask),
        .rd_addr    (rd_addr),
        .rd_zone_id (rd_zone_id),
        .rd_ready   (rd_ready),
        .rvalid     (rvalid),
        .rdata      (rdata)
`ifdef ACCUM_PERF_CNT_EN
        ,
        .perf_accum_cnt    (perf_accum_cnt),
        .perf_rd_stall_cnt (perf_rd_stall_cnt)
`endif
    );

    typedef struct {
        logic         wen;
        logic         wv;
        logic         acc;
        logic [3:0]   wmask;
        logic [8:0]   waddr;
        logic [1:0]   wzone;
        logic [255:0] wdat;
        logic [3:0]   rmask;
        logic [8:0]   raddr;
        logic [1:0]   rzone;
        logic [255:0] exp;
        string        nm;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    function automatic logic [255:0] all4(input logic [63:0] w);
        return {4{w}};
    endfunction

    function automatic vec_t mk(input logic wen, input logic wv, input logic acc,
                                input logic [3:0] wmask, input logic [8:0] waddr,
                                input logic [1:0] wzone, input logic [255:0] wdat,
                                input logic [3:0] rmask, input logic [8:0] raddr,
                                input logic [1:0] rzone, input logic [255:0] exp,
                                input string nm);
        vec_t v;
        v.wen = wen; v.wv = wv; v.acc = acc; v.wmask = wmask; v.waddr = waddr;
        v.wzone = wzone; v.wdat = wdat; v.rmask = rmask; v.raddr = raddr;
        v.rzone = rzone; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_wr(input logic acc, input logic wv, input logic [3:0] m,
                            input logic [8:0] a, input logic [1:0] z, input logic [255:0] d);
        wr_valid = 1'b1; wvalid = wv; accum_en = acc; wr_mask = m;
        wr_addr = a; wr_zone_id = z; wdata = d;
        if (acc && wv) n_accum++;
        @(posedge clk);
        #1;
        wr_valid = 1'b0; wvalid = 1'b0; accum_en = 1'b0; wr_mask = '0;
    endtask

    task automatic do_read(input logic [3:0] m, input logic [8:0] a, input logic [1:0] z,
                           input logic [255:0] exp, input string nm);
        rd_valid = 1'b1; rd_mask = m; rd_addr = a; rd_zone_id = z;
        @(negedge clk);
        chk({nm, "_rdy"}, 256'(rd_ready), 256'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0; rd_mask = '0;
        @(negedge clk);
        chk({nm, "_rvalid"}, 256'(rvalid), 256'd1);
        chk({nm, "_rdata"}, rdata, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 1, 0, 4'hF, 9'd5, 2'd0, all4(rep(16'h0003)),
                     4'hF, 9'd5, 2'd0, all4(rep(16'h0003)), "plain_wr_rd");
        vecs[1] = mk(1, 1, 0, 4'hF, 9'd6, 2'd0, all4(64'h0001_0000_1234_FFFF),
                     4'hF, 9'd6, 2'd0, all4(64'h0001_0000_1234_FFFF), "pattern_wr");
        vecs[2] = mk(1, 1, 1, 4'hF, 9'd6, 2'd0, all4(64'h0000_0000_0000_0002),
                     4'hF, 9'd6, 2'd0, all4(64'h0001_0000_1234_0001), "lane_wrap");
        vecs[3] = mk(1, 1, 1, 4'hF, 9'd6, 2'd0, all4(64'h8000_FFFF_0001_0000),
                     4'hF, 9'd6, 2'd0, all4(64'h8001_FFFF_1235_0001), "lane_mix");
        vecs[4] = mk(1, 1, 0, 4'hF, 9'd6, 2'd1, all4(rep(16'hAAAA)),
                     4'hF, 9'd6, 2'd1, all4(rep(16'hAAAA)), "zone1_wr");
        vecs[5] = mk(0, 0, 0, 4'h0, 9'd6, 2'd1, '0,
                     4'hF, 9'd6, 2'd0, all4(64'h8001_FFFF_1235_0001), "zone0_isolated");
        vecs[6] = mk(1, 1, 0, 4'hF, 9'd10, 2'd0,
                     {rep(16'h0040), rep(16'h0030), rep(16'h0020), rep(16'h0010)},
                     4'hF, 9'd10, 2'd0,
                     {rep(16'h0040), rep(16'h0030), rep(16'h0020), rep(16'h0010)}, "bank_pattern");
        vecs[7] = mk(1, 1, 1, 4'b0101, 9'd10, 2'd0, all4(rep(16'h0005)),
                     4'b0011, 9'd10, 2'd0,
                     {64'd0, 64'd0, rep(16'h0020), rep(16'h0015)}, "masked_accum");
        vecs[8] = mk(1, 1, 0, 4'b1000, 9'd10, 2'd0, all4(rep(16'h7777)),
                     4'hF, 9'd10, 2'd0,
                     {rep(16'h7777), rep(16'h0035), rep(16'h0020), rep(16'h0015)}, "masked_plain");
        vecs[9] = mk(1, 0, 0, 4'hF, 9'd5, 2'd0, all4(rep(16'h9999)),
                     4'hF, 9'd5, 2'd0, all4(rep(16'h0003)), "wr_without_wvalid");

        rstn = 1'b0;
        wr_valid = 1'b0; wvalid = 1'b0; accum_en = 1'b0; wr_mask = '0;
        wr_addr = '0; wr_zone_id = '0; wdata = '0;
        rd_valid = 1'b1; rd_mask = 4'hF; rd_addr = '0; rd_zone_id = '0;

        repeat (2) @(negedge clk);
        chk("reset_rvalid", 256'(rvalid), 256'd0);
        chk("reset_rdata", rdata, 256'd0);
        chk("reset_rd_ready", 256'(rd_ready), 256'd0);
`ifdef ACCUM_PERF_CNT_EN
        chk("reset_perf_accum", 256'(perf_accum_cnt), 256'd0);
        chk("reset_perf_stall", 256'(perf_rd_stall_cnt), 256'd0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rd_valid = 1'b0; rd_mask = '0;
        @(negedge clk);
        chk("idle_rvalid", 256'(rvalid), 256'd0);
        chk("idle_rd_ready", 256'(rd_ready), 256'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wen)
                drive_wr(vecs[i].acc, vecs[i].wv, vecs[i].wmask, vecs[i].waddr,
                         vecs[i].wzone, vecs[i].wdat);
            else
                idle(1);
            idle(2);
            do_read(vecs[i].rmask, vecs[i].raddr, vecs[i].rzone, vecs[i].exp, vecs[i].nm);
        end

        // Four back-to-back +1 accumulates: each one depends on the previous via S2 forwarding
        drive_wr(0, 1, 4'hF, 9'd7, 2'd0, '0);
        idle(2);
        for (int k = 0; k < 4; k++) drive_wr(1, 1, 4'hF, 9'd7, 2'd0, all4(rep(16'h0001)));
        idle(2);
        do_read(4'hF, 9'd7, 2'd0, all4(rep(16'h0004)), "accum4");

        // Accumulates two cycles apart: the second one must pick up the first from S3
        drive_wr(0, 1, 4'hF, 9'd13, 2'd0, all4(rep(16'h0100)));
        idle(2);
        drive_wr(1, 1, 4'hF, 9'd13, 2'd0, all4(rep(16'h0010)));
        idle(1);
        drive_wr(1, 1, 4'hF, 9'd13, 2'd0, all4(rep(16'h0001)));
        idle(2);
        do_read(4'hF, 9'd13, 2'd0, all4(rep(16'h0111)), "s3_fwd");

        // Accumulate with a read to the same address held
        drive_wr(0, 1, 4'hF, 9'd9, 2'd0, all4(rep(16'h0100)));
        idle(2);
        wr_valid = 1'b1; wvalid = 1'b1; accum_en = 1'b1; wr_mask = 4'hF;
        wr_addr = 9'd9; wr_zone_id = 2'd0; wdata = all4(rep(16'h0001));
        n_accum++;
        rd_valid = 1'b1; rd_mask = 4'hF; rd_addr = 9'd9; rd_zone_id = 2'd0;
        @(negedge clk);
        chk("haz_n_rdy", 256'(rd_ready), 256'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0; wvalid = 1'b0; accum_en = 1'b0; wr_mask = '0;
        @(negedge clk);
        chk("haz_n1_rdy", 256'(rd_ready), 256'd0);
        chk("haz_n1_rvalid", 256'(rvalid), 256'd0);
        chk("haz_n1_rdata", rdata, 256'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("haz_n2_rdy", 256'(rd_ready), 256'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("haz_n3_rdy", 256'(rd_ready), 256'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0; rd_mask = '0;
        @(negedge clk);
        chk("haz_rvalid", 256'(rvalid), 256'd1);
        chk("haz_rdata", rdata, all4(rep(16'h0101)));
        @(posedge clk);
        #1;

        // Plain write and read in the same cycle: read sees pre-write data, then stalls
        drive_wr(0, 1, 4'hF, 9'd11, 2'd0, all4(rep(16'h0042)));
        idle(2);
        wr_valid = 1'b1; wvalid = 1'b1; accum_en = 1'b0; wr_mask = 4'hF;
        wr_addr = 9'd11; wr_zone_id = 2'd0; wdata = all4(rep(16'h0099));
        rd_valid = 1'b1; rd_mask = 4'hF; rd_addr = 9'd11; rd_zone_id = 2'd0;
        @(negedge clk);
        chk("rbw_rdy", 256'(rd_ready), 256'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0; wvalid = 1'b0; wr_mask = '0;
        @(negedge clk);
        chk("rbw_rvalid", 256'(rvalid), 256'd1);
        chk("rbw_rdata_old", rdata, all4(rep(16'h0042)));
        chk("rbw_stall1", 256'(rd_ready), 256'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rbw_stall2", 256'(rd_ready), 256'd0);
        chk("rbw_stall2_rvalid", 256'(rvalid), 256'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rbw_n3_rdy", 256'(rd_ready), 256'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0; rd_mask = '0;
        @(negedge clk);
        chk("rbw_new_rvalid", 256'(rvalid), 256'd1);
        chk("rbw_new_rdata", rdata, all4(rep(16'h0099)));
        @(posedge clk);
        #1;

`ifdef ACCUM_PERF_CNT_EN
        chk("perf_accum_count", 256'(perf_accum_cnt), 256'(n_accum));
`endif

        // Reset with S1/S2 occupied and a read response in flight
        drive_wr(0, 1, 4'hF, 9'd12, 2'd0, all4(rep(16'h0011)));
        idle(2);
        drive_wr(1, 1, 4'hF, 9'd12, 2'd0, all4(rep(16'h0001)));
        wr_valid = 1'b1; wvalid = 1'b1; accum_en = 1'b0; wr_mask = 4'hF;
        wr_addr = 9'd12; wr_zone_id = 2'd0; wdata = all4(rep(16'h5555));
        rd_valid = 1'b1; rd_mask = 4'hF; rd_addr = 9'd5; rd_zone_id = 2'd0;
        @(posedge clk);
        #1;
        wr_valid = 1'b0; wvalid = 1'b0; wr_mask = '0;
        rd_valid = 1'b0; rd_mask = '0;
        chk("prerst_rvalid", 256'(rvalid), 256'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_rvalid", 256'(rvalid), 256'd0);
        chk("midrst_rdata", rdata, 256'd0);
        chk("midrst_rd_ready", 256'(rd_ready), 256'd0);
`ifdef ACCUM_PERF_CNT_EN
        chk("midrst_perf_accum", 256'(perf_accum_cnt), 256'd0);
        chk("midrst_perf_stall", 256'(perf_rd_stall_cnt), 256'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3);
        do_read(4'hF, 9'd12, 2'd0, all4(rep(16'h0011)), "postrst_no_write");
        do_read(4'hF, 9'd5, 2'd0, all4(rep(16'h0003)), "postrst_addr5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
